// File: rtl/sram_slot_arbiter_if.sv
// Client/video/SRAM-control bundle for the time-slotted frame-buffer arbiter.
// The bidirectional SRAM data bus stays a plain port on the arbiter.
interface sram_slot_arbiter_if #(
   parameter int X_WIDTH     = 9,
   parameter int Y_WIDTH     = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLIENTS = 2
);
   logic [1:0]                         slotPhase;
   logic [X_WIDTH-1:0]                 videoXCoord;
   logic [Y_WIDTH-1:0]                 videoYCoord;
   logic [DATA_WIDTH-1:0]              videoData;
   logic                               videoDataReady;
   logic [NUM_CLIENTS*X_WIDTH-1:0]     clientXCoord;
   logic [NUM_CLIENTS*Y_WIDTH-1:0]     clientYCoord;
   logic [NUM_CLIENTS-1:0]             clientReadRequest;
   logic [NUM_CLIENTS-1:0]             clientWriteRequest;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0]  clientWriteData;
   logic [NUM_CLIENTS-1:0]             clientGrant;
   logic [DATA_WIDTH-1:0]              clientReadData;
   logic [NUM_CLIENTS-1:0]             clientReadComplete;
   logic [NUM_CLIENTS-1:0]             clientWriteComplete;
   logic [X_WIDTH+Y_WIDTH-1:0]         ramAddress;
   logic                               ramOutputEnable;
   logic                               ramWriteEnable;

   // Arbiter side
   modport slave (
      output slotPhase, videoData, videoDataReady, clientGrant, clientReadData,
             clientReadComplete, clientWriteComplete, ramAddress,
             ramOutputEnable, ramWriteEnable,
      input  videoXCoord, videoYCoord, clientXCoord, clientYCoord,
             clientReadRequest, clientWriteRequest, clientWriteData
   );

   // Requester side (video fetch + clients)
   modport master (
      input  slotPhase, videoData, videoDataReady, clientGrant, clientReadData,
             clientReadComplete, clientWriteComplete, ramAddress,
             ramOutputEnable, ramWriteEnable,
      output videoXCoord, videoYCoord, clientXCoord, clientYCoord,
             clientReadRequest, clientWriteRequest, clientWriteData
   );
endinterface

// File: rtl/sram_slot_arbiter.sv
// Time-slotted arbiter for a single asynchronous frame-buffer SRAM.
// A free-running 4-cycle frame (IDLE, VIDEO, ACCESS, COMPLETE) gives the
// video refresh one guaranteed read and shares one access slot round-robin
// among NUM_CLIENTS read/write clients. Every SRAM control is a flop loaded
// from the phase being entered, so the pins never glitch.
module sram_slot_arbiter #(
   parameter int X_WIDTH     = 9,
   parameter int Y_WIDTH     = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLIENTS = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   sram_slot_arbiter_if.slave    bus,
   inout  wire [DATA_WIDTH-1:0]  ramData
);
   localparam int AW = X_WIDTH + Y_WIDTH;
   localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   typedef enum logic [1:0] {
      PH_IDLE     = 2'd0,
      PH_VIDEO    = 2'd1,
      PH_ACCESS   = 2'd2,
      PH_COMPLETE = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_t;

   phase_t                  phase_q;
   op_t                     op_q;
   logic [PW-1:0]           ptr_q;
   logic [AW-1:0]           addr_q;
   logic                    oe_n_q;
   logic                    we_n_q;
   logic                    drive_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   vdata_q;
   logic                    vrdy_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [NUM_CLIENTS-1:0]  grant_q;
   logic [NUM_CLIENTS-1:0]  rcomp_q;
   logic [NUM_CLIENTS-1:0]  wcomp_q;

   // Candidate vector: any client holding a read or write request
   logic [NUM_CLIENTS-1:0]  cand;
   for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_cand
      assign cand[k] = bus.clientReadRequest[k] | bus.clientWriteRequest[k];
   end

   // Rotate candidates so bit 0 is the client the pointer names
   logic [2*NUM_CLIENTS-1:0] cand_dbl;
   logic [NUM_CLIENTS-1:0]   cand_rot;
   assign cand_dbl = {cand, cand} >> ptr_q;
   assign cand_rot = cand_dbl[NUM_CLIENTS-1:0];

   logic                    found_d;
   logic [PW-1:0]           win_d;
   logic [PW-1:0]           ptr_d;

   // First candidate at or after the pointer, ascending with wrap
   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (!found_d && cand_rot[i]) begin
            found_d = 1'b1;
            win_d   = PW'((int'(ptr_q) + i) % NUM_CLIENTS);
         end
      end
      ptr_d = PW'((int'(win_d) + 1) % NUM_CLIENTS);
   end

   logic [NUM_CLIENTS-1:0]  onehot_d;
   logic [X_WIDTH-1:0]      win_x_d;
   logic [Y_WIDTH-1:0]      win_y_d;
   logic [DATA_WIDTH-1:0]   win_wdata_d;
   logic                    win_wr_d;

   // Mux the winning client's address, data and operation out of the packed buses
   always_comb begin
      onehot_d    = '0;
      win_x_d     = '0;
      win_y_d     = '0;
      win_wdata_d = '0;
      win_wr_d    = 1'b0;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
         if (win_d == PW'(j)) begin
            onehot_d[j] = found_d;
            win_x_d     = bus.clientXCoord[j*X_WIDTH +: X_WIDTH];
            win_y_d     = bus.clientYCoord[j*Y_WIDTH +: Y_WIDTH];
            win_wdata_d = bus.clientWriteData[j*DATA_WIDTH +: DATA_WIDTH];
            win_wr_d    = bus.clientWriteRequest[j];
         end
      end
   end

   // Frame sequencer: each edge loads the controls of the phase being entered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_q <= PH_IDLE;
         op_q    <= OP_NOP;
         ptr_q   <= '0;
         addr_q  <= '0;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         drive_q <= 1'b0;
         wdata_q <= '0;
         vdata_q <= '0;
         vrdy_q  <= 1'b0;
         rdata_q <= '0;
         grant_q <= '0;
         rcomp_q <= '0;
         wcomp_q <= '0;
      end else begin
         phase_q <= phase_t'(phase_q + 2'd1);
         case (phase_q)
            // Entering VIDEO: present the refresh address and open the read
            PH_IDLE: begin
               addr_q <= {bus.videoYCoord, bus.videoXCoord};
               oe_n_q <= 1'b0;
               we_n_q <= 1'b1;
            end
            // Entering ACCESS: capture the pixel, arbitrate, set up the slot
            PH_VIDEO: begin
               vdata_q <= ramData;
               vrdy_q  <= 1'b1;
               if (found_d) begin
                  grant_q <= onehot_d;
                  ptr_q   <= ptr_d;
                  addr_q  <= {win_y_d, win_x_d};
                  wdata_q <= win_wdata_d;
                  if (win_wr_d) begin
                     op_q    <= OP_WRITE;
                     oe_n_q  <= 1'b1;
                     we_n_q  <= 1'b0;
                     drive_q <= 1'b1;
                  end else begin
                     op_q    <= OP_READ;
                     oe_n_q  <= 1'b0;
                     we_n_q  <= 1'b1;
                  end
               end else begin
                  op_q   <= OP_NOP;
                  oe_n_q <= 1'b1;
                  we_n_q <= 1'b1;
               end
            end
            // Entering COMPLETE: close the strobe, capture read data, signal done;
            // write data stays on the bus one more cycle as hold margin
            PH_ACCESS: begin
               vrdy_q <= 1'b0;
               oe_n_q <= 1'b1;
               we_n_q <= 1'b1;
               if (op_q == OP_READ) begin
                  rdata_q <= ramData;
                  rcomp_q <= grant_q;
               end
               if (op_q == OP_WRITE) begin
                  wcomp_q <= grant_q;
               end
            end
            // Entering IDLE: release the bus and retire the slot owner
            default: begin
               op_q    <= OP_NOP;
               drive_q <= 1'b0;
               grant_q <= '0;
               rcomp_q <= '0;
               wcomp_q <= '0;
            end
         endcase
      end
   end

   assign ramData                 = drive_q ? wdata_q : 'z;

   assign bus.slotPhase           = phase_q;
   assign bus.videoData           = vdata_q;
   assign bus.videoDataReady      = vrdy_q;
   assign bus.clientGrant         = grant_q;
   assign bus.clientReadData      = rdata_q;
   assign bus.clientReadComplete  = rcomp_q;
   assign bus.clientWriteComplete = wcomp_q;
   assign bus.ramAddress          = addr_q;
   assign bus.ramOutputEnable     = oe_n_q;
   assign bus.ramWriteEnable      = we_n_q;
endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter: a 2-client instance with a simple
// address-derived SRAM read model, plus a 3-client instance for rotation.
module tb_sram_slot_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   wire [7:0] ramData2;
   wire [7:0] ramData3;
   logic [7:0] rd2;

   sram_slot_arbiter_if #(.X_WIDTH(9), .Y_WIDTH(8), .DATA_WIDTH(8), .NUM_CLIENTS(2)) bus2 ();
   sram_slot_arbiter_if #(.X_WIDTH(9), .Y_WIDTH(8), .DATA_WIDTH(8), .NUM_CLIENTS(3)) bus3 ();

   sram_slot_arbiter #(.X_WIDTH(9), .Y_WIDTH(8), .DATA_WIDTH(8), .NUM_CLIENTS(2)) dut2 (
      .clock(clk), .reset(rst_n), .bus(bus2), .ramData(ramData2));
   sram_slot_arbiter #(.X_WIDTH(9), .Y_WIDTH(8), .DATA_WIDTH(8), .NUM_CLIENTS(3)) dut3 (
      .clock(clk), .reset(rst_n), .bus(bus3), .ramData(ramData3));

   // SRAM read model: one preloaded location, otherwise low address byte ^ C3
   always_comb rd2 = (bus2.ramAddress == 17'h1DF3F) ? 8'h3C : (bus2.ramAddress[7:0] ^ 8'hC3);
   assign ramData2 = bus2.ramOutputEnable ? 8'hzz : rd2;
   assign ramData3 = bus3.ramOutputEnable ? 8'hzz : 8'h77;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [2:0] exp3 [4];
   int n;
   logic done;

   initial begin
      checks = 0; failures = 0;
      exp3 = '{3'b001, 3'b010, 3'b100, 3'b001};
      rst_n = 1'b0;
      bus2.videoXCoord = 9'h012; bus2.videoYCoord = 8'h34;
      bus2.clientXCoord = '0; bus2.clientYCoord = '0; bus2.clientWriteData = '0;
      bus2.clientReadRequest = '0; bus2.clientWriteRequest = '0;
      bus3.videoXCoord = '0; bus3.videoYCoord = '0;
      bus3.clientXCoord = '0; bus3.clientYCoord = '0; bus3.clientWriteData = '0;
      bus3.clientReadRequest = '0; bus3.clientWriteRequest = '0;
      repeat (2) tick();

      // Reset state
      chk("rst_phase", 32'(bus2.slotPhase), 0);
      chk("rst_oe", 32'(bus2.ramOutputEnable), 1);
      chk("rst_we", 32'(bus2.ramWriteEnable), 1);
      chk("rst_addr", 32'(bus2.ramAddress), 0);
      chk("rst_vdata", 32'(bus2.videoData), 0);
      chk("rst_vrdy", 32'(bus2.videoDataReady), 0);
      chk("rst_grant", 32'(bus2.clientGrant), 0);
      chk("rst_rdata", 32'(bus2.clientReadData), 0);
      chk("rst_rcomp", 32'(bus2.clientReadComplete), 0);
      chk("rst_wcomp", 32'(bus2.clientWriteComplete), 0);
      rst_n = 1'b1;

      // Idle frames: phase walk, OE only in VIDEO, video pixel each frame
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk("idle_phase", 32'(bus2.slotPhase), 32'(c % 4));
         chk("idle_oe", 32'(bus2.ramOutputEnable), (c % 4 == 1) ? 0 : 1);
         chk("idle_we", 32'(bus2.ramWriteEnable), 1);
         chk("idle_vrdy", 32'(bus2.videoDataReady), (c % 4 == 2) ? 1 : 0);
         chk("idle_grant", 32'(bus2.clientGrant), 0);
         if (c % 4 == 1) chk("idle_vaddr", 32'(bus2.ramAddress), 32'h06812);
         if (c % 4 == 2) chk("idle_vdata", 32'(bus2.videoData), 32'hD1);
      end

      // Client 0 write x=5 y=3 data A5
      bus2.clientXCoord = {9'd0, 9'd5}; bus2.clientYCoord = {8'd0, 8'd3};
      bus2.clientWriteData = {8'h00, 8'hA5}; bus2.clientWriteRequest = 2'b01;
      tick();
      chk("wr_video_oe", 32'(bus2.ramOutputEnable), 0);
      tick();
      chk("wr_addr", 32'(bus2.ramAddress), 32'h605);
      chk("wr_we_acc", 32'(bus2.ramWriteEnable), 0);
      chk("wr_oe_acc", 32'(bus2.ramOutputEnable), 1);
      chk("wr_data_acc", 32'(ramData2), 32'hA5);
      chk("wr_grant", 32'(bus2.clientGrant), 32'b01);
      chk("wr_wcomp_acc", 32'(bus2.clientWriteComplete), 0);
      tick();
      chk("wr_we_cmp", 32'(bus2.ramWriteEnable), 1);
      chk("wr_data_cmp", 32'(ramData2), 32'hA5);
      chk("wr_wcomp", 32'(bus2.clientWriteComplete), 32'b01);
      chk("wr_rcomp", 32'(bus2.clientReadComplete), 0);
      chk("wr_grant_cmp", 32'(bus2.clientGrant), 32'b01);
      tick();
      chk("wr_wcomp_end", 32'(bus2.clientWriteComplete), 0);
      chk("wr_grant_end", 32'(bus2.clientGrant), 0);
      bus2.clientWriteRequest = 2'b00;

      // Client 1 read x=13F y=EF, model returns 3C
      bus2.clientXCoord = {9'h13F, 9'd0}; bus2.clientYCoord = {8'hEF, 8'd0};
      bus2.clientReadRequest = 2'b10;
      tick();
      tick();
      chk("rd_addr", 32'(bus2.ramAddress), 32'h1DF3F);
      chk("rd_oe_acc", 32'(bus2.ramOutputEnable), 0);
      chk("rd_we_acc", 32'(bus2.ramWriteEnable), 1);
      chk("rd_grant", 32'(bus2.clientGrant), 32'b10);
      tick();
      chk("rd_data", 32'(bus2.clientReadData), 32'h3C);
      chk("rd_rcomp", 32'(bus2.clientReadComplete), 32'b10);
      chk("rd_wcomp", 32'(bus2.clientWriteComplete), 0);
      chk("rd_oe_cmp", 32'(bus2.ramOutputEnable), 1);
      tick();
      chk("rd_rcomp_end", 32'(bus2.clientReadComplete), 0);
      bus2.clientReadRequest = 2'b00;

      // Request withdrawn before the grant edge: slot must be a NOP
      bus2.clientReadRequest = 2'b10;
      tick();
      bus2.clientReadRequest = 2'b00;
      tick();
      chk("drop_grant", 32'(bus2.clientGrant), 0);
      chk("drop_oe", 32'(bus2.ramOutputEnable), 1);
      chk("drop_we", 32'(bus2.ramWriteEnable), 1);
      chk("drop_addr_hold", 32'(bus2.ramAddress), 32'h06812);
      tick();
      chk("drop_rcomp", 32'(bus2.clientReadComplete), 0);
      tick();

      // Client 0 read+write together: write wins, read data untouched
      bus2.clientXCoord = {9'd0, 9'd1}; bus2.clientYCoord = {8'd0, 8'd1};
      bus2.clientWriteData = {8'h00, 8'h5E};
      bus2.clientReadRequest = 2'b01; bus2.clientWriteRequest = 2'b01;
      tick();
      tick();
      chk("rw_addr", 32'(bus2.ramAddress), 32'h201);
      chk("rw_we", 32'(bus2.ramWriteEnable), 0);
      chk("rw_oe", 32'(bus2.ramOutputEnable), 1);
      chk("rw_data", 32'(ramData2), 32'h5E);
      chk("rw_grant", 32'(bus2.clientGrant), 32'b01);
      tick();
      chk("rw_wcomp", 32'(bus2.clientWriteComplete), 32'b01);
      chk("rw_rcomp", 32'(bus2.clientReadComplete), 0);
      chk("rw_rdata", 32'(bus2.clientReadData), 32'h3C);
      tick();
      bus2.clientReadRequest = 2'b00; bus2.clientWriteRequest = 2'b00;

      // Three clients requesting continuously: rotation 001,010,100,001
      bus3.clientReadRequest = 3'b111;
      for (int f = 0; f < 4; f++) begin
         tick();
         tick();
         chk("rr3_phase", 32'(bus3.slotPhase), 2);
         chk("rr3_grant", 32'(bus3.clientGrant), 32'(exp3[f]));
         chk("rr3_vrdy", 32'(bus3.videoDataReady), 1);
         chk("rr3_vdata", 32'(bus3.videoData), 32'h77);
         tick();
         chk("rr3_rcomp", 32'(bus3.clientReadComplete), 32'(exp3[f]));
         tick();
      end
      bus3.clientReadRequest = 3'b000;

      // Reset during a write ACCESS, then the held request completes
      bus2.clientXCoord = {9'd0, 9'd2}; bus2.clientYCoord = '0;
      bus2.clientWriteData = {8'h00, 8'h99}; bus2.clientWriteRequest = 2'b01;
      tick();
      tick();
      chk("mr_we_pre", 32'(bus2.ramWriteEnable), 0);
      chk("mr_data_pre", 32'(ramData2), 32'h99);
      rst_n = 1'b0;
      #1;
      chk("mr_we", 32'(bus2.ramWriteEnable), 1);
      chk("mr_oe", 32'(bus2.ramOutputEnable), 1);
      chk("mr_phase", 32'(bus2.slotPhase), 0);
      chk("mr_grant", 32'(bus2.clientGrant), 0);
      chk("mr_addr", 32'(bus2.ramAddress), 0);
      tick();
      chk("mr_wcomp", 32'(bus2.clientWriteComplete), 0);
      rst_n = 1'b1;
      n = 0; done = 1'b0;
      while (!done && n < 12) begin
         tick();
         n++;
         if (n == 1) chk("mr_restart_phase", 32'(bus2.slotPhase), 1);
         if (bus2.clientWriteComplete == 2'b01) done = 1'b1;
      end
      chk("mr_done", 32'(done), 1);
      chk("mr_latency", 32'(n), 3);
      bus2.clientWriteRequest = 2'b00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
